// File: rtl/sordm5_mem_pkg.sv
// sordm5_mem_pkg: shared types and address-map defaults for the Sord M5 memory arbiter
package sordm5_mem_pkg;
    typedef enum logic [1:0] {IDLE, BUSY, GAP} state_t;
    typedef enum logic [1:0] {REQ_DL, REQ_CPU, REQ_AUX} req_id_t;
    localparam int AW_DEF = 25;
    localparam logic [AW_DEF-1:0] ROM_BASE_DEF = 25'h000000;
    localparam logic [AW_DEF-1:0] BIN_BASE_DEF = 25'h010000;
endpackage

// File: rtl/sordm5_mem_arbiter_if.sv
// sordm5_mem_arbiter_if: byte-wide request/ack memory port; master issues, slave completes
interface sordm5_mem_arbiter_if #(parameter int AW = 25);
    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [7:0]    din;
    logic [7:0]    dout;
    logic          ack;
    modport master (output req, we, addr, din, input dout, ack);
    modport slave (input req, we, addr, din, output dout, ack);
endinterface

// File: rtl/sordm5_dl_buffer.sv
// sordm5_dl_buffer: one-entry ioctl loader buffer with ROM/BINROM mapping, overrun flag and dl_done
module sordm5_dl_buffer
    import sordm5_mem_pkg::*;
#(
    parameter int            AW       = AW_DEF,
    parameter logic [AW-1:0] ROM_BASE = AW'(ROM_BASE_DEF),
    parameter logic [AW-1:0] BIN_BASE = AW'(BIN_BASE_DEF)
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic          ioctl_download,
    input  logic [7:0]    ioctl_index,
    input  logic          ioctl_wr,
    input  logic [AW-1:0] ioctl_addr,
    input  logic [7:0]    ioctl_dout,
    input  logic          dl_clear,
    input  logic          dl_serving,
    output logic          dl_pending,
    output logic [AW-1:0] dl_addr,
    output logic [7:0]    dl_data,
    output logic          dl_done,
    output logic          dl_overrun
);
    logic dl_seen;
    logic accept;
    // a completing entry frees the slot in the same cycle, so a coincident byte is not an overrun
    assign accept  = ioctl_wr && (!dl_pending || dl_clear);
    assign dl_done = dl_seen && !ioctl_download && !dl_pending && !dl_serving;
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            dl_pending <= 1'b0;
            dl_addr    <= '0;
            dl_data    <= '0;
            dl_overrun <= 1'b0;
            dl_seen    <= 1'b0;
        end else begin
            dl_pending <= accept || (dl_pending && !dl_clear);
            dl_addr    <= accept ? (ioctl_index == 8'd0 ? ROM_BASE : BIN_BASE) + ioctl_addr : dl_addr;
            dl_data    <= accept ? ioctl_dout : dl_data;
            dl_overrun <= dl_overrun || (ioctl_wr && !accept);
            dl_seen    <= ioctl_download || (dl_seen && !dl_done);
        end
    end
endmodule

// File: rtl/sordm5_mem_arbiter.sv
// sordm5_mem_arbiter: shares one SDRAM byte port among ioctl loader, Z80 CPU and an aux requester
module sordm5_mem_arbiter
    import sordm5_mem_pkg::*;
#(
    parameter int            AW         = AW_DEF,
    parameter logic [AW-1:0] ROM_BASE   = AW'(ROM_BASE_DEF),
    parameter logic [AW-1:0] BIN_BASE   = AW'(BIN_BASE_DEF),
    parameter int            STARVE_MAX = 4
) (
    input  logic                        clk_sys,
    input  logic                        reset,
    input  logic                        ioctl_download,
    input  logic [7:0]                  ioctl_index,
    input  logic                        ioctl_wr,
    input  logic [AW-1:0]               ioctl_addr,
    input  logic [7:0]                  ioctl_dout,
    output logic                        dl_done,
    output logic                        dl_overrun,
    sordm5_mem_arbiter_if.slave         cpu,
    sordm5_mem_arbiter_if.slave         aux,
    sordm5_mem_arbiter_if.master        mem
);
    localparam int SW = $clog2(STARVE_MAX + 1);
    state_t        state;
    req_id_t       winner;
    req_id_t       pick;
    logic [SW-1:0] starve_cnt;
    logic          dl_pending;
    logic [AW-1:0] dl_addr;
    logic [7:0]    dl_data;
    logic          cpu_ok;
    logic          aux_ok;
    logic          grant;
    logic          pick_we;
    logic [AW-1:0] pick_addr;
    logic [7:0]    pick_din;
    logic          dl_serving;
    logic          dl_clear;
    sordm5_dl_buffer #(.AW(AW), .ROM_BASE(ROM_BASE), .BIN_BASE(BIN_BASE)) u_dl (
        .clk_sys        (clk_sys),
        .reset          (reset),
        .ioctl_download (ioctl_download),
        .ioctl_index    (ioctl_index),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .dl_clear       (dl_clear),
        .dl_serving     (dl_serving),
        .dl_pending     (dl_pending),
        .dl_addr        (dl_addr),
        .dl_data        (dl_data),
        .dl_done        (dl_done),
        .dl_overrun     (dl_overrun)
    );
    assign dl_serving = state == BUSY && winner == REQ_DL;
    assign dl_clear   = dl_serving && mem.ack;
    // a download in progress locks out cpu and aux even when the loader buffer is empty
    always_comb begin
        cpu_ok    = !ioctl_download && cpu.req;
        aux_ok    = !ioctl_download && aux.req;
        grant     = state == IDLE && (dl_pending || cpu_ok || aux_ok);
        pick      = dl_pending ? REQ_DL
                  : aux_ok && (!cpu_ok || starve_cnt == SW'(STARVE_MAX)) ? REQ_AUX : REQ_CPU;
        pick_we   = pick == REQ_DL || (pick == REQ_AUX ? aux.we : cpu.we);
        pick_addr = pick == REQ_DL ? dl_addr : pick == REQ_AUX ? aux.addr : cpu.addr;
        pick_din  = pick == REQ_DL ? dl_data : pick == REQ_AUX ? aux.din : cpu.din;
    end
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state      <= IDLE;
            winner     <= REQ_DL;
            starve_cnt <= '0;
            mem.req    <= 1'b0;
            mem.we     <= 1'b0;
            mem.addr   <= '0;
            mem.din    <= '0;
            cpu.ack    <= 1'b0;
            cpu.dout   <= '0;
            aux.ack    <= 1'b0;
            aux.dout   <= '0;
        end else begin
            cpu.ack <= 1'b0;
            aux.ack <= 1'b0;
            if (!aux.req || (grant && pick == REQ_AUX))
                starve_cnt <= '0;
            else if (grant && pick == REQ_CPU && starve_cnt != SW'(STARVE_MAX))
                starve_cnt <= starve_cnt + 1'b1;
            case (state)
                IDLE: if (grant) begin
                    winner   <= pick;
                    mem.req  <= 1'b1;
                    mem.we   <= pick_we;
                    mem.addr <= pick_addr;
                    mem.din  <= pick_din;
                    state    <= BUSY;
                end
                BUSY: if (mem.ack) begin
                    mem.req  <= 1'b0;
                    state    <= GAP;
                    cpu.ack  <= winner == REQ_CPU;
                    aux.ack  <= winner == REQ_AUX;
                    cpu.dout <= winner == REQ_CPU ? mem.dout : cpu.dout;
                    aux.dout <= winner == REQ_AUX ? mem.dout : aux.dout;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
